pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for carrying a packed control/data bundle between stages such as ID->EX and EX->MEM.
- Replaces the per-stage hand-written control registers.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush that inserts a configurable bubble value, and saturating stall/flush event counters for performance debug.

Parameters:
- WIDTH, 32, width of the payload bundle in bits.
- CLEAR_VALUE, {WIDTH{1'b0}}, payload value presented on out_data while out_valid=0, and after flush/reset.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous flush; kills all held entries.
- in_valid  input  1  upstream presents a valid payload.
- in_ready  output  1  stage can accept the payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds a valid payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  WIDTH  payload; equals CLEAR_VALUE when out_valid=0.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0 (saturating).
- flush_cnt  output  CNT_W  flushes that killed at least one valid entry (saturating).

Behaviour:
- Reset (async, highest priority):
  - out_valid=0, out_data=CLEAR_VALUE.
  - stall_cnt=0, flush_cnt=0.
  - Skid entry invalid; in_ready=1 from the first cycle after reset deasserts.
- Transfers:
  - Accept occurs when in_valid & in_ready.
  - Issue occurs when out_valid & out_ready.
  - Payload order is strictly FIFO; no payload is lost or duplicated.
- Latency: 1 cycle from accept to out_valid in an empty stage.
- Throughput: 1 transfer per cycle while out_ready=1.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept, the main register loads in_data.
  - On issue without accept, out_valid drops to 0.
- SKID=1, states EMPTY, ONE and TWO:
  - EMPTY: accept -> ONE.
  - ONE: accept & !issue -> TWO, with the new payload placed in the skid register. issue & !accept -> EMPTY. Accept & issue -> ONE, with main loading in_data.
  - TWO: issue -> ONE, with skid moving to main. No accept is possible in TWO.
  - in_ready is a register output, equal to 1 in EMPTY/ONE and 0 in TWO.
  - There is no combinational path from out_ready to in_ready.
- Flush:
  - Priority order is reset > flush_i > normal operation.
  - On flush, the next state is EMPTY: out_valid=0, main and skid hold CLEAR_VALUE, and in_ready=1 next cycle.
  - A payload offered in the flush cycle is dropped, even if in_ready=1.
  - An issue in the flush cycle is still a completed transfer downstream.
  - flush_cnt increments only if any entry was valid at the flush edge.
- Counters: saturate at all-ones and never wrap.
- Simultaneous events:
  - Flush with stall counts the stall cycle.
  - Flush with accept drops the accepted payload.
- out_data must never show stale data while out_valid=0; downstream relies on CLEAR_VALUE acting as a bubble, with all control bits 0.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams ST_EMPTY/ST_ONE/ST_TWO.
  - Typedefs of the packed per-stage control bundles (ID->EX, EX->MEM, MEM->WB) and their widths, used as WIDTH.
- Sub-module sat_counter (parameter W; inputs inc, clr; output cnt) is natural, instantiated twice.
- Skid datapath stays inline.

Test Plan:
- Reset mid-stream: with TWO full, assert reset -> out_valid=0, out_data=CLEAR_VALUE, counters 0, in_ready=1 after release.
- Streaming, SKID=1, out_ready=1: in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later, out_valid=1 throughout, stall_cnt=0.
- Backpressure: push 0xA1,0xA2 with out_ready=0 -> in_ready=0 after the second accept. Hold 3 cycles -> stall_cnt=4. Release -> 0xA1 then 0xA2, in_ready returns to 1.
- Flush with TWO full plus in_valid=1 (0xB3) -> next cycle out_valid=0, out_data=CLEAR_VALUE, flush_cnt=1, 0xB3 never appears.
- Flush while EMPTY -> flush_cnt unchanged.
- Saturation, CNT_W=3: hold a stall for 10 cycles -> stall_cnt stays 7. Repeat streaming and backpressure with SKID=0 -> identical output order, in_ready tracks out_ready in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared definitions for the pipeline stage registers: skid-stage
//             state encoding and the packed per-stage control/data bundles
//             whose widths are used as the WIDTH parameter of pipe_stage_reg.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Occupancy state of a stage register (number of held entries).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef logic [1:0] stateT;

    // Decode -> execute bundle.
    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        aluSrcImm;
        logic [3:0]  aluOp;
        logic [4:0]  rd;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
    } idExT;

    // Execute -> memory bundle.
    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic [4:0]  rd;
        logic [31:0] aluResult;
        logic [31:0] storeData;
    } exMemT;

    // Memory -> writeback bundle.
    typedef struct packed {
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] wbData;
    } memWbT;

    localparam int ID_EX_W  = $bits(idExT);
    localparam int EX_MEM_W = $bits(exMemT);
    localparam int MEM_WB_W = $bits(memWbT);

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Event counter that sticks at all-ones instead of wrapping.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous active-high reset (count -> 0)
//             inc   - count one event this cycle
//             clr   - synchronous clear (wins over inc)
//             cnt   - current count, W bits
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Generic pipeline stage register with valid/ready handshake,
//             optional 2-entry skid buffer, synchronous flush that inserts a
//             bubble (CLEAR_VALUE) and saturating stall/flush counters.
//  Ports    : clk, reset             - clock / async active-high reset
//             flush_i                - synchronous flush, kills held entries
//             in_valid/in_ready/in_data    - upstream handshake + payload
//             out_valid/out_ready/out_data - downstream handshake + payload
//             stall_cnt              - cycles with out_valid & !out_ready
//             flush_cnt              - flushes that killed a valid entry
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}},
    parameter int               SKID        = 1,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stateT            r_state;
    stateT            w_nextState;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_nextMain;
    logic [WIDTH-1:0] w_nextSkid;
    logic             w_inReady;
    logic             w_outValid;
    logic             w_accept;
    logic             w_issue;

    assign w_outValid = (r_state != ST_EMPTY);
    assign w_accept   = in_valid & w_inReady;
    assign w_issue    = w_outValid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_main  <= CLEAR_VALUE;
            r_skid  <= CLEAR_VALUE;
        end else begin
            r_state <= w_nextState;
            r_main  <= w_nextMain;
            r_skid  <= w_nextSkid;
        end
    end

    // Whenever an entry leaves, its register is reloaded with CLEAR_VALUE so
    // out_data is a clean bubble whenever out_valid is low.
    always_comb begin
        w_nextState = r_state;
        w_nextMain  = r_main;
        w_nextSkid  = r_skid;
        if (flush_i) begin
            w_nextState = ST_EMPTY;
            w_nextMain  = CLEAR_VALUE;
            w_nextSkid  = CLEAR_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_nextState = ST_ONE;
                        w_nextMain  = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_issue) begin
                        w_nextState = ST_TWO;
                        w_nextSkid  = in_data;
                    end else if (w_issue && !w_accept) begin
                        w_nextState = ST_EMPTY;
                        w_nextMain  = CLEAR_VALUE;
                    end else if (w_issue && w_accept) begin
                        w_nextMain  = in_data;
                    end
                end
                ST_TWO: begin
                    if (w_issue) begin
                        w_nextState = ST_ONE;
                        w_nextMain  = r_skid;
                        w_nextSkid  = CLEAR_VALUE;
                    end
                end
                default: begin
                    w_nextState = ST_EMPTY;
                    w_nextMain  = CLEAR_VALUE;
                    w_nextSkid  = CLEAR_VALUE;
                end
            endcase
        end
    end

    // With the skid buffer, in_ready is registered from the next occupancy so
    // out_ready never reaches in_ready combinationally. Without it, in_ready
    // is combinational and the stage never holds more than one entry.
    generate
        if (SKID != 0) begin : g_skid
            logic r_inReady;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_inReady <= 1'b1;
                end else begin
                    r_inReady <= (w_nextState != ST_TWO);
                end
            end
            assign w_inReady = r_inReady;
        end else begin : g_noSkid
            assign w_inReady = !w_outValid | out_ready;
        end
    endgenerate

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_outValid & !out_ready),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_i & w_outValid),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_data  = r_main;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. Two instances share one
//             stimulus stream: dutA (SKID=1, CNT_W=3) and dutB (SKID=0,
//             CNT_W=16). Each has a FIFO reference model / scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    localparam logic [7:0] CLR_A = 8'hC3;
    localparam logic [7:0] CLR_B = 8'h00;

    typedef logic [7:0] byteQ[$];

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       flush_i   = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data   = 8'h00;

    logic        inReadyA, outValidA, inReadyB, outValidB;
    logic [7:0]  outDataA, outDataB;
    logic [2:0]  stallA, flushA;
    logic [15:0] stallB, flushB;

    byteQ mq[2];
    int   mStall[2];
    int   mFlush[2];
    int   checks = 0;
    int   errors = 0;

    pipe_stage_reg #(.WIDTH(8), .CLEAR_VALUE(CLR_A), .SKID(1), .CNT_W(3)) dutA (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(inReadyA), .in_data(in_data),
        .out_valid(outValidA), .out_ready(out_ready), .out_data(outDataA),
        .stall_cnt(stallA), .flush_cnt(flushA)
    );

    pipe_stage_reg #(.WIDTH(8), .CLEAR_VALUE(CLR_B), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(inReadyB), .in_data(in_data),
        .out_valid(outValidB), .out_ready(out_ready), .out_data(outDataB),
        .stall_cnt(stallB), .flush_cnt(flushB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h @%0t", nm, id, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    task automatic checkDut(input int id, input logic iRdy, input logic oVal,
                            input logic [7:0] oDat, input int sCnt, input int fCnt);
        logic [7:0] clrv;
        logic       expRdy;
        logic [7:0] expDat;
        int         sizeBefore;
        int         cMax;
        clrv = (id == 0) ? CLR_A : CLR_B;
        cMax = (id == 0) ? 7 : 65535;
        if (reset) begin
            chk("rst_out_valid", id, int'(oVal), 0);
            chk("rst_out_data",  id, int'(oDat), int'(clrv));
            chk("rst_stall_cnt", id, sCnt, 0);
            chk("rst_flush_cnt", id, fCnt, 0);
            mq[id].delete();
            mStall[id] = 0;
            mFlush[id] = 0;
            return;
        end
        sizeBefore = mq[id].size();
        expRdy = (id == 0) ? (sizeBefore < 2) : ((sizeBefore == 0) || out_ready);
        chk("in_ready",  id, int'(iRdy), int'(expRdy));
        chk("out_valid", id, int'(oVal), int'(sizeBefore > 0));
        chk("stall_cnt", id, sCnt, mStall[id]);
        chk("flush_cnt", id, fCnt, mFlush[id]);
        if (sizeBefore == 0) begin
            chk("bubble_data", id, int'(oDat), int'(clrv));
        end else if (out_ready) begin
            expDat = mq[id].pop_front();
            chk("issue_data", id, int'(oDat), int'(expDat));
        end else begin
            chk("held_data", id, int'(oDat), int'(mq[id][0]));
        end
        if ((sizeBefore > 0) && !out_ready && (mStall[id] < cMax)) mStall[id]++;
        if (flush_i) begin
            if ((sizeBefore > 0) && (mFlush[id] < cMax)) mFlush[id]++;
            mq[id].delete();
        end else if (in_valid && expRdy) begin
            mq[id].push_back(in_data);
        end
    endtask

    always @(negedge clk) begin
        checkDut(0, inReadyA, outValidA, outDataA, int'(stallA), int'(flushA));
        checkDut(1, inReadyB, outValidB, outDataB, int'(stallB), int'(flushB));
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush_i   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // streaming
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        drive(1'b1, 8'h22, 1'b1, 1'b0);
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
        // backpressure
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
        // flush with the stage full and a payload offered
        drive(1'b1, 8'hA4, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, 8'hB3, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
        // flush while empty
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        // long stall for counter saturation
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
        // reset mid-stream with the stage full
        drive(1'b1, 8'hD1, 1'b0, 1'b0);
        drive(1'b1, 8'hD2, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
        // randomized traffic
        repeat (400) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
